// File: rtl/psc_pkg.sv
// psc_pkg -- shared definitions for the prescaled up/down counter.
//   psc_div   : prescaler division ratio from clock and tick rates
//   psc_clog2 : register width needed to hold 0..n-1 (never below 1)
//   PSC_CLK_HZ / PSC_TICK_HZ / PSC_MOD : default configuration
package psc_pkg;

    localparam int unsigned PSC_CLK_HZ  = 50000000;
    localparam int unsigned PSC_TICK_HZ = 1;
    localparam int unsigned PSC_MOD     = 10000;

    // A zero tick rate yields 0 so the DIV >= 2 guard in the top trips.
    function automatic int unsigned psc_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
        return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
    endfunction

    function automatic int unsigned psc_clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while (w < 32 && (64'd1 << w) < 64'(n))
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/psc_prescaler.sv
// psc_prescaler -- free-running divide-by-DIV prescaler.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset, clears the phase register
//   en    : 1 = advance, 0 = freeze phase
//   clr   : synchronous restart of the period (phase back to 0)
//   tick  : one-cycle pulse in the last cycle of each period
module psc_prescaler
    import psc_pkg::*;
#(
    parameter int unsigned DIV = psc_div(PSC_CLK_HZ, PSC_TICK_HZ)
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     CDIV = psc_clog2(DIV);
    localparam logic [CDIV-1:0] LAST = CDIV'(DIV - 1);

    logic [CDIV-1:0] p;

    // Reset and a restart both win over the period end, so no pulse escapes
    // in a cycle whose phase is being discarded.
    assign tick = en & ~reset & ~clr & (p == LAST);

    always_ff @(posedge clock) begin
        if (reset || clr)
            p <= '0;
        else if (en)
            p <= (p == LAST) ? '0 : p + CDIV'(1);
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter -- modulo-MOD up/down counter advanced by a
// CLK_HZ/TICK_HZ prescaler.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   en        : 1 = prescaler and counter run, 0 = both freeze
//   ud        : direction, 1 = up, 0 = down (sampled on tick)
//   load      : synchronous load strobe (ignores en, restarts the period)
//   load_val  : load value, clamped to MOD-1
//   tick      : prescaler period pulse
//   count     : registered count, 0..MOD-1
//   tc        : terminal count for the current direction (combinational)
//   wrap      : registered pulse the cycle after a tick wraps the count
//   alarm_val : (PSC_ALARM_EN only) alarm compare value
//   alarm     : (PSC_ALARM_EN only) pulse the cycle after a tick lands on alarm_val
// Optional feature macro: PSC_ALARM_EN.
module prescaled_updown_counter
    import psc_pkg::*;
#(
    parameter int unsigned CLK_HZ  = PSC_CLK_HZ,
    parameter int unsigned TICK_HZ = PSC_TICK_HZ,
    parameter int unsigned MOD     = PSC_MOD,
    parameter int unsigned CW      = $clog2(MOD)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          ud,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tick,
    output logic [CW-1:0] count,
    output logic          tc,
    output logic          wrap
`ifdef PSC_ALARM_EN
    ,
    input  logic [CW-1:0] alarm_val,
    output logic          alarm
`endif
);

    localparam int unsigned   DIV = psc_div(CLK_HZ, TICK_HZ);
    localparam logic [CW-1:0] TOP = CW'(MOD - 1);

    if (DIV < 2) begin : g_bad_div
        $error("prescaled_updown_counter: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (MOD < 2) begin : g_bad_mod
        $error("prescaled_updown_counter: MOD must be >= 2");
    end

    logic          at_top;
    logic          at_zero;
    logic          edge_hit;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] lv_clamp;

    psc_prescaler #(.DIV(DIV)) u_psc (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign at_top   = (count == TOP);
    assign at_zero  = (count == '0);
    // The boundary in the current direction doubles as tc and as the
    // "this tick wraps" condition.
    assign edge_hit = ud ? at_top : at_zero;
    assign tc       = edge_hit;

    always_comb begin
        cnt_nxt = count;
        if (ud)
            cnt_nxt = at_top ? '0 : count + CW'(1);
        else
            cnt_nxt = at_zero ? TOP : count - CW'(1);
    end

    // Compare in 32 bits: MOD itself may not fit in CW bits.
    assign lv_clamp = (32'(load_val) >= MOD) ? TOP : load_val;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= lv_clamp;
            wrap  <= 1'b0;
        end else if (tick) begin
            count <= cnt_nxt;
            wrap  <= edge_hit;
        end else begin
            wrap  <= 1'b0;
        end
    end

`ifdef PSC_ALARM_EN
    // tick is already suppressed under reset/load, so loads never alarm.
    always_ff @(posedge clock) begin
        if (reset || load)
            alarm <= 1'b0;
        else
            alarm <= tick && (cnt_nxt == alarm_val);
    end
`endif

endmodule

// File: tb/tb_prescaled_updown_counter.sv
module tb_prescaled_updown_counter;

    localparam int DIV = 5;   // CLK_HZ=10, TICK_HZ=2
    localparam int MOD = 4;
    localparam int CW  = 3;   // wider than needed so out-of-range loads can be driven

    logic          clk = 1'b0;
    logic          reset, en, ud, load;
    logic [CW-1:0] load_val;
    logic          tick, tc, wrap;
    logic [CW-1:0] count;
`ifdef PSC_ALARM_EN
    logic [CW-1:0] alarm_val;
    logic          alarm;
`endif

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int m_phase = 0;
    int m_cnt   = 0;
    int m_wrap  = 0;
    int m_alarm = 0;

    always #5 clk = ~clk;

    prescaled_updown_counter #(
        .CLK_HZ (10),
        .TICK_HZ(2),
        .MOD    (MOD),
        .CW     (CW)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .en       (en),
        .ud       (ud),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
`ifdef PSC_ALARM_EN
        ,
        .alarm_val(alarm_val),
        .alarm    (alarm)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle against the model, then
    // advance the model by the rules for the edge that ends this cycle.
    task automatic step();
        int exp_tick, exp_tc, nc;
        @(negedge clk);
        exp_tick = (en && !reset && !load && m_phase == DIV - 1) ? 1 : 0;
        exp_tc   = ud ? int'(m_cnt == MOD - 1) : int'(m_cnt == 0);
        chk("tick",  int'(tick),  exp_tick);
        chk("count", int'(count), m_cnt);
        chk("wrap",  int'(wrap),  m_wrap);
        chk("tc",    int'(tc),    exp_tc);
`ifdef PSC_ALARM_EN
        chk("alarm", int'(alarm), m_alarm);
`endif
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_wrap = 0; m_alarm = 0;
        end else if (load) begin
            m_cnt   = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
            m_phase = 0; m_wrap = 0; m_alarm = 0;
        end else if (en) begin
            if (exp_tick == 1) begin
                nc      = ud ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
                m_wrap  = ud ? int'(m_cnt == MOD - 1) : int'(m_cnt == 0);
`ifdef PSC_ALARM_EN
                m_alarm = int'(nc == int'(alarm_val));
`else
                m_alarm = 0;
`endif
                m_cnt   = nc;
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
                m_wrap  = 0; m_alarm = 0;
            end
        end else begin
            m_wrap = 0; m_alarm = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance (with current inputs) until the model phase equals ph.
    task automatic run_to_phase(input int ph);
        int k;
        k = 0;
        while (m_phase != ph && k < 4 * DIV) begin
            step();
            k++;
        end
        chk("phase_reach", m_phase, ph);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; ud = 1'b1; load = 1'b0; load_val = '0;
`ifdef PSC_ALARM_EN
        alarm_val = 3'd2;
`endif
        @(posedge clk);
        #1;
        run(2);                         // reset state

        // up counting through a full wrap
        reset = 1'b0; en = 1'b1; ud = 1'b1;
        run(4 * DIV + 3);

        // down from 0 wraps to MOD-1, then flip direction mid-period
        run_to_phase(0);
        ud = 1'b0;
        run(DIV + 2);
        ud = 1'b1;
        run(2);
        ud = 1'b0;
        run(DIV);
        ud = 1'b1;

        // load coincident with a tick, then an out-of-range load
        run_to_phase(DIV - 1);
        load = 1'b1; load_val = 3'd2;
        step();
        load = 1'b0;
        chk("load_val2", int'(count), 2);
        run(DIV + 1);
        load = 1'b1; load_val = 3'd7; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        chk("load_clamp", int'(count), 3);
        run(2);

        // freeze at phase 3 for 7 cycles
        run_to_phase(3);
        en = 1'b0;
        run(7);
        en = 1'b1;
        run(DIV + 1);

        // reset at phase 4 with count 2
        load = 1'b1; load_val = 3'd2;
        step();
        load = 1'b0;
        run_to_phase(DIV - 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(2 * DIV + 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 5);
            en       = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 10) ud = ~ud;
            load_val = CW'($urandom_range(0, 7));
`ifdef PSC_ALARM_EN
            if ($urandom_range(0, 99) < 3) alarm_val = CW'($urandom_range(0, MOD - 1));
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/prescaled_updown_counter.md
PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

Interface
REQ-001 Parameter CLK_HZ, default 50000000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1: count rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 required (elaboration error otherwise).
REQ-003 Parameter MOD, default 10000: count modulus; count range 0..MOD-1, MOD >= 2.
REQ-004 Parameter CW, default $clog2(MOD): count width in bits.
REQ-005 Port clock  in  1  sole clock, rising edge.
REQ-006 Port reset  in  1  reset, synchronous and active-high, the one clock domain.
REQ-007 Port en  in  1  1 = prescaler and counter run; 0 = both freeze.
REQ-008 Port ud  in  1  direction: 1 = up, 0 = down; sampled on each tick.
REQ-009 Port load  in  1  synchronous load strobe.
REQ-010 Port load_val  in  CW  value loaded on load.
REQ-011 Port tick  out  1  one-cycle pulse each prescaler period.
REQ-012 Port count  out  CW  current count, registered.
REQ-013 Port tc  out  1  level: count==MOD-1 when ud=1, count==0 when ud=0 (combinational from count, ud).
REQ-014 Port wrap  out  1  registered one-cycle pulse on the cycle count wraps.

Function
REQ-015 Prescaler: CDIV-bit register p, counts 0..DIV-1 while en=1; tick=1 in the cycle p==DIV-1 and en=1; next p=0.
REQ-016 On tick with ud=1: count<=count+1, MOD-1 -> 0 with wrap=1 in the next cycle.
REQ-017 On tick with ud=0: count<=count-1, 0 -> MOD-1 with wrap=1 in the next cycle.
REQ-018 Count changes only on tick, load or reset; latency tick -> new count = 1 cycle.
REQ-019 en=0: p, count held; tick=0; wrap=0 from the next cycle.
REQ-020 load=1: count<=load_val (clamped to MOD-1 if load_val >= MOD), p<=0, wrap<=0; load overrides a coincident tick; en is ignored.
REQ-021 ud change mid-period takes effect at the next tick; p is not disturbed.
REQ-022 Priority per cycle: reset > load > tick > hold.
REQ-023 wrap is never asserted for a load that moves count across a boundary.

Reset
REQ-024 reset=1 at a rising edge: p=0, count=0, wrap=0; tick=0 during that cycle.
REQ-025 Reset mid-period discards partial prescaler progress; first tick after release arrives DIV cycles after the first en=1 cycle.
REQ-026 All state registers reset; no other reset behaviour exists.

Configuration
REQ-027 Macro PSC_ALARM_EN defined: adds port alarm_val (in, CW) and alarm (out, 1): registered one-cycle pulse the cycle after a tick moves count to alarm_val; load to alarm_val does not fire; alarm=0 in reset.
REQ-028 PSC_ALARM_EN undefined: alarm_val and alarm ports and logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package psc_pkg holds the function computing DIV, the clog2 width helper, and the default CLK_HZ/TICK_HZ/MOD constants.
REQ-030 Prescaler is a sub-module psc_prescaler (params DIV; ports clock, reset, en, clr, tick); the counter/wrap/alarm logic sits in the top.

Verification (CLK_HZ=10, TICK_HZ=2 -> DIV=5, MOD=4 unless stated)
REQ-031 reset 2 cycles, en=1, ud=1 -> tick every 5th cycle; count 0,1,2,3,0; wrap pulse one cycle after the 3->0 tick; tc=1 while count=3.
REQ-032 ud=0 from count=0 -> next tick count=3, wrap=1 one cycle later; tc=1 at count=0; tc falls when ud switches to 1.
REQ-033 load=1, load_val=2 coincident with a tick -> count=2, no increment, p=0, next tick 5 cycles later; load_val=7 -> count=3.
REQ-034 en=0 for 7 cycles at p=3 -> count, p frozen, no tick; tick arrives 1 cycle after en returns high.
REQ-035 reset asserted at p=4 with count=2 -> count=0, wrap=0, no tick that cycle; first tick 5 cycles after release.
REQ-036 PSC_ALARM_EN, alarm_val=2, up counting -> alarm pulse one cycle after the tick reaching 2; load_val=2 -> no alarm; without macro the bench compiles without alarm ports.
